fetch_unit: RTL and testbench

- Program-counter / fetch sequencer that drives the instruction ROM address.
- Sits directly upstream of the control decoder and consumes the decoder's BranchEn plus the ALU Zero flag to select the next PC.
- Provides the Start/Done program handshake to the testbench/top level.
- Honours a Stall from the data-memory side and stops on a Halt decode.

---
 rtl/fetch_unit.sv | 129 ++++++++++++
 tb/tb_fetch_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Program-counter / fetch sequencer with Start/Done handshake, stall and halt.
// Optional FETCH_COUNT_EN adds a saturating 16-bit InstCnt output. Assumes PC_W > OFF_W.
module fetch_unit #(
  parameter int          PC_W       = 10,
  parameter int          OFF_W      = 6,
  parameter int unsigned START_ADDR = 0
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Start,
  input  logic                    BranchEn,
  input  logic                    Zero,
  input  logic signed [OFF_W-1:0] Offset,
  input  logic                    Halt,
  input  logic                    Stall,
  output logic [PC_W-1:0]         ProgCtr,
  output logic                    Running,
`ifdef FETCH_COUNT_EN
  output logic [15:0]             InstCnt,
`endif
  output logic                    Done
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    DONE    = 2'b10,
    ILLEGAL = 2'b11
  } state_e;

  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              running_q, running_d;
  logic              done_q, done_d;
  logic              start_acc;

  function automatic logic [PC_W-1:0] sext_off(input logic signed [OFF_W-1:0] off);
    return {{(PC_W-OFF_W){off[OFF_W-1]}}, off};
  endfunction

  // Start is only honoured from IDLE or DONE; it is ignored while running.
  assign start_acc = Start && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = RUN;
          pc_d    = START_PC;
        end
      end
      RUN: begin
        // Stall freezes everything, so a halt seen under stall waits for Stall to drop.
        if (!Stall) begin
          if (Halt) begin
            state_d = DONE;
          end else if (BranchEn && Zero) begin
            pc_d = pc_q + sext_off(Offset);
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      DONE: begin
        if (Start) begin
          state_d = RUN;
          pc_d    = START_PC;
        end
      end
      default: state_d = IDLE;
    endcase
    running_d = (state_d == RUN);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      pc_q      <= START_PC;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign ProgCtr = pc_q;
  assign Running = running_q;
  assign Done    = done_q;

`ifdef FETCH_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Every non-stalled RUN edge retires one instruction, the halting edge included.
  always_comb begin
    cnt_d = cnt_q;
    if (start_acc) begin
      cnt_d = 16'd0;
    end else if ((state_q == RUN) && !Stall) begin
      cnt_d = sat_inc16(cnt_q);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign InstCnt = cnt_q;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit plus hand-written async reset and restart sequences.
module tb_fetch_unit;
  localparam int PC_W  = 10;
  localparam int OFF_W = 6;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              Start, BranchEn, Zero, Halt, Stall;
  logic [OFF_W-1:0]  Offset;
  logic [PC_W-1:0]   ProgCtr;
  logic              Running, Done;
`ifdef FETCH_COUNT_EN
  logic [15:0]       InstCnt;
`endif

  fetch_unit #(.PC_W(PC_W), .OFF_W(OFF_W), .START_ADDR(0)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .BranchEn(BranchEn), .Zero(Zero),
    .Offset(Offset), .Halt(Halt), .Stall(Stall), .ProgCtr(ProgCtr), .Running(Running),
`ifdef FETCH_COUNT_EN
    .InstCnt(InstCnt),
`endif
    .Done(Done)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic            start, br, z;
    logic [OFF_W-1:0] off;
    logic            halt, stall;
    logic [PC_W-1:0] pc;
    logic            run, done;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic apply(input logic st, input logic br, input logic z, input logic [OFF_W-1:0] off,
                       input logic h, input logic sl);
    Start = st; BranchEn = br; Zero = z; Offset = off; Halt = h; Stall = sl;
    @(posedge Clk);
    #1;
  endtask

  task automatic add(input logic st, input logic br, input logic z, input logic [OFF_W-1:0] off,
                     input logic h, input logic sl, input int pc, input logic run, input logic dn);
    vec_t v;
    v.start = st; v.br = br; v.z = z; v.off = off; v.halt = h; v.stall = sl;
    v.pc = PC_W'(pc); v.run = run; v.done = dn;
    vecs.push_back(v);
  endtask

  initial begin
    //   st br z  off         h  sl  pc    run done
    add(1, 0, 0, 6'd0,       0, 0,  0,    1, 0);
    add(0, 0, 0, 6'd0,       0, 0,  1,    1, 0);
    add(0, 0, 0, 6'd0,       0, 0,  2,    1, 0);
    add(0, 0, 0, 6'd0,       0, 0,  3,    1, 0);
    add(0, 0, 0, 6'd0,       0, 0,  4,    1, 0);
    add(0, 0, 0, 6'd0,       0, 0,  5,    1, 0);
    add(0, 1, 1, 6'b111101,  0, 0,  2,    1, 0);  // taken -3
    add(0, 0, 0, 6'd0,       0, 0,  3,    1, 0);
    add(0, 0, 0, 6'd0,       0, 0,  4,    1, 0);
    add(0, 0, 0, 6'd0,       0, 0,  5,    1, 0);
    add(0, 1, 0, 6'b111101,  0, 0,  6,    1, 0);  // not taken
    add(1, 0, 0, 6'd0,       0, 0,  7,    1, 0);  // Start ignored in RUN
    add(0, 0, 0, 6'd0,       1, 1,  7,    1, 0);  // halt under stall
    add(0, 0, 0, 6'd0,       1, 1,  7,    1, 0);
    add(0, 0, 0, 6'd0,       1, 1,  7,    1, 0);
    add(0, 0, 0, 6'd0,       1, 0,  7,    0, 1);
    add(0, 0, 0, 6'd0,       0, 0,  7,    0, 1);  // DONE holds
    add(0, 1, 1, 6'd5,       0, 0,  7,    0, 1);
    add(1, 0, 0, 6'd0,       0, 0,  0,    1, 0);  // restart
    add(0, 1, 1, 6'd0,       0, 0,  0,    1, 0);  // self loop
    add(0, 1, 1, 6'd5,       1, 0,  0,    0, 1);  // halt beats branch
    add(1, 0, 0, 6'd0,       0, 0,  0,    1, 0);
    add(0, 0, 0, 6'd0,       0, 0,  1,    1, 0);
    add(0, 0, 0, 6'd0,       0, 0,  2,    1, 0);
    add(0, 1, 1, 6'b111100,  0, 0,  1022, 1, 0);  // -4 past zero
    add(0, 0, 0, 6'd0,       0, 0,  1023, 1, 0);
    add(0, 0, 0, 6'd0,       0, 0,  0,    1, 0);  // top wrap
    add(0, 1, 1, 6'b011111,  0, 0,  31,   1, 0);
    add(0, 1, 1, 6'd9,       0, 0,  40,   1, 0);

    Reset = 1'b1; Start = 0; BranchEn = 0; Zero = 0; Offset = '0; Halt = 0; Stall = 0;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    check("reset pc", ProgCtr, 0);
    check("reset running", Running, 0);
    check("reset done", Done, 0);
    apply(0, 1, 1, 6'd3, 1, 0);
    check("idle ignores pc", ProgCtr, 0);
    check("idle ignores running", Running, 0);
    check("idle ignores done", Done, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].start, vecs[i].br, vecs[i].z, vecs[i].off, vecs[i].halt, vecs[i].stall);
      check($sformatf("vec%0d pc", i), ProgCtr, vecs[i].pc);
      check($sformatf("vec%0d running", i), Running, vecs[i].run);
      check($sformatf("vec%0d done", i), Done, vecs[i].done);
    end

    // Asynchronous reset between edges while running at PC=40.
    #2 Reset = 1'b1;
    #1;
    check("async rst pc", ProgCtr, 0);
    check("async rst running", Running, 0);
    check("async rst done", Done, 0);
    #2 Reset = 1'b0;
    apply(0, 0, 0, 6'd0, 0, 0);
    check("post rst idle pc", ProgCtr, 0);
    check("post rst idle running", Running, 0);
    apply(1, 0, 0, 6'd0, 0, 0);
    check("post rst start pc", ProgCtr, 0);
    check("post rst start running", Running, 1);
`ifdef FETCH_COUNT_EN
    check("cnt after start", InstCnt, 0);
`endif

    // Ten-instruction program (PCs 0..9), two stall cycles before the halt at PC 9.
    for (int k = 1; k <= 9; k++) begin
      apply(0, 0, 0, 6'd0, 0, 0);
      check($sformatf("prog pc%0d", k), ProgCtr, k);
    end
    apply(0, 0, 0, 6'd0, 1, 1);
    apply(0, 0, 0, 6'd0, 1, 1);
    check("prog stall pc", ProgCtr, 9);
    check("prog stall done", Done, 0);
`ifdef FETCH_COUNT_EN
    check("cnt during stall", InstCnt, 9);
`endif
    apply(0, 0, 0, 6'd0, 1, 0);
    check("prog halt pc", ProgCtr, 9);
    check("prog halt done", Done, 1);
`ifdef FETCH_COUNT_EN
    check("cnt at halt", InstCnt, 10);
`endif
    apply(0, 0, 0, 6'd0, 0, 0);
    check("prog done hold", Done, 1);
`ifdef FETCH_COUNT_EN
    check("cnt holds in done", InstCnt, 10);
`endif
    apply(1, 0, 0, 6'd0, 0, 0);
    check("restart pc", ProgCtr, 0);
    check("restart done", Done, 0);
    check("restart running", Running, 1);
`ifdef FETCH_COUNT_EN
    check("cnt restart clear", InstCnt, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
